ram_burst_writer: RTL and testbench
===================================

Name: ram_burst_writer

Overview:
- Write-side master for port A of the 32K x 16 dual-port RAM.
- Takes a start command (base address, word count) and a valid/ready data stream, and writes the stream to consecutive RAM addresses with wrap-around.
- Optionally reads the burst back through the same port and compares a 16-bit checksum against the one computed while writing.
- It is the writer counterpart of the sequential port-A address scanner used to read the RAM.

Parameters:
ADDR_W, 15, RAM address width (depth 2**ADDR_W)
DATA_W, 16, RAM data width
RD_LAT, 1, RAM read latency in clka cycles (douta valid RD_LAT cycles after addra)

Ports:
clka  in  1  clock; all logic on rising edge
rsta  in  1  synchronous, active-high reset
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_W  first RAM address of burst
word_count  in  ADDR_W+1  words to write, 0..2**ADDR_W
verify_en  in  1  sampled with start; 1 = run readback pass
s_data  in  DATA_W  stream data
s_valid  in  1  stream data valid
s_ready  out  1  block accepts s_data this cycle
wea  out  1  RAM port A write enable (registered)
addra  out  ADDR_W  RAM port A address (registered)
dina  out  DATA_W  RAM port A write data (registered)
douta  in  DATA_W  RAM port A read data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at burst end
verify_err  out  1  readback checksum mismatch; held until next start
checksum  out  DATA_W  sum mod 2**DATA_W of written words; held until next start

Behaviour:
- Reset (rsta=1 at edge): state IDLE. wea, addra, dina, s_ready, busy, done, verify_err and checksum all 0. Internal counters and sums cleared.
- Reset mid-burst aborts immediately: wea=0 after the reset edge, no done pulse, remaining words are not written.
- States: IDLE -> WRITE -> (VERIFY) -> DONE -> IDLE.
- IDLE:
  - start=1 latches base_addr, word_count and verify_en; clears checksum and verify_err; busy=1 next cycle.
  - word_count=0 goes straight to DONE: no writes, checksum 0, verify_err 0.
  - start while busy is ignored.
- WRITE:
  - s_ready=1 while remaining>0.
  - Each cycle with s_valid&s_ready: next cycle wea=1, addra=current address, dina=s_data.
  - checksum += s_data (mod 2**DATA_W); address increments mod 2**ADDR_W (0x7FFF wraps to 0x0000); remaining decrements.
  - Cycles with s_valid=0 give wea=0; addra/dina hold.
  - Write latency: 1 cycle from accept to RAM strobe.
  - On the accept of the last word, next state is VERIFY if verify_en else DONE; s_ready=0 from the following cycle.
- VERIFY:
  - Issues word_count reads, one per cycle, wea=0, addra = base_addr .. base_addr+word_count-1 (wrapping).
  - The first read is issued the cycle after the last write strobe, so it never overlaps a write.
  - An RD_LAT-deep valid shift register marks when douta is sampled; sampled words accumulate into rd_sum.
  - After the last read data returns: verify_err = (rd_sum != checksum); go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, back to IDLE. A start in the DONE cycle is ignored.
- Outputs after a burst: addra holds its last value; wea=0 outside WRITE strobes.

Test Plan:
- Reset then start base=0x0000 count=4 verify_en=0, stream 0x0001,0x0002,0x0003,0x0004 back-to-back:
  - wea pulses 4 consecutive cycles at addra 0..3 with matching dina.
  - checksum=0x000A; done one cycle after the last strobe; verify_err=0.
- base=0x7FFE count=4, stream 0xFFFF x4 with s_valid low every other cycle:
  - writes at 0x7FFE,0x7FFF,0x0000,0x0001, one per valid cycle.
  - checksum=0xFFFC (wrap of sum).
- verify_en=1, base=0x0100 count=3, data 0x1111,0x2222,0x3333 into a RAM model:
  - 3 reads at 0x0100..0x0102 follow.
  - checksum=0x6666, verify_err=0, done after the last read returns.
- Same as previous, but the RAM model corrupts address 0x0101 to 0x2223 -> verify_err=1, held until the next start.
- start with count=0 -> no wea, done the cycle after DONE is entered, checksum=0; start asserted mid-WRITE is ignored.
- rsta asserted after 2 of 8 words accepted:
  - wea=0 from the next cycle, no done pulse, all outputs 0.
  - A new burst then runs correctly.

Source files
------------

// File: rtl/ram_burst_writer.sv
// Port-A write master for the dual-port RAM. It streams a burst of words to
// consecutive, wrapping addresses and keeps a running checksum. It can
// optionally read the burst back and compare the readback checksum.
module ram_burst_writer #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic              verify_en,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   input  logic [DATA_W-1:0] douta,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic              ver_q;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   rd_issue;
   logic [ADDR_W:0]   rd_left;
   // Bit 0 marks that addra carries a read in this cycle. Bit RD_LAT marks
   // the cycle in which the matching douta is valid.
   logic [RD_LAT:0]   rd_vld;
   logic [DATA_W-1:0] rd_sum;
   logic [DATA_W-1:0] rd_sum_nxt;
   logic              accept;

   assign accept = s_valid & s_ready;

   // The readback sum includes the word that returns in this cycle, so the final compare sees every word
   always_comb begin
      rd_sum_nxt = rd_sum + douta;
   end

   // Burst control FSM; all port-A signals and status outputs are registered here
   always_ff @(posedge clka) begin
      if (rsta) begin
         state      <= IDLE;
         ver_q      <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         remaining  <= '0;
         rd_issue   <= '0;
         rd_left    <= '0;
         rd_vld     <= '0;
         rd_sum     <= '0;
         s_ready    <= 1'b0;
         wea        <= 1'b0;
         addra      <= '0;
         dina       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         verify_err <= 1'b0;
         checksum   <= '0;
      end else begin
         wea    <= 1'b0;
         done   <= 1'b0;
         rd_vld <= {rd_vld[RD_LAT-1:0], 1'b0};
         case (state)
            IDLE: begin
               if (start) begin
                  ver_q      <= verify_en;
                  wr_addr    <= base_addr;
                  rd_addr    <= base_addr;
                  remaining  <= word_count;
                  rd_issue   <= word_count;
                  rd_left    <= word_count;
                  rd_sum     <= '0;
                  checksum   <= '0;
                  verify_err <= 1'b0;
                  busy       <= 1'b1;
                  if (word_count == '0) begin
                     s_ready <= 1'b0;
                     state   <= DONE;
                  end else begin
                     s_ready <= 1'b1;
                     state   <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (accept) begin
                  wea       <= 1'b1;
                  addra     <= wr_addr;
                  dina      <= s_data;
                  checksum  <= checksum + s_data;
                  wr_addr   <= wr_addr + 1'b1;
                  remaining <= remaining - ONE;
                  if (remaining == ONE) begin
                     s_ready <= 1'b0;
                     state   <= ver_q ? VERIFY : DONE;
                  end
               end
            end
            VERIFY: begin
               // The first read issues one cycle after the last write strobe,
               // so port A never carries a read and a write in the same cycle.
               if (rd_issue != '0) begin
                  addra     <= rd_addr;
                  rd_addr   <= rd_addr + 1'b1;
                  rd_issue  <= rd_issue - ONE;
                  rd_vld[0] <= 1'b1;
               end
               if (rd_vld[RD_LAT]) begin
                  rd_sum  <= rd_sum_nxt;
                  rd_left <= rd_left - ONE;
                  if (rd_left == ONE) begin
                     verify_err <= (rd_sum_nxt != checksum);
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_writer.sv
// Randomised bench for ram_burst_writer. It uses a RAM model with optional
// read corruption. Expected writes, checksums and verify results are derived
// from the burst parameters with plain arithmetic.
module tb_ram_burst_writer;

   localparam int RD_LAT = 1;

   logic        clka = 1'b0;
   logic        rsta = 1'b1;
   logic        start = 1'b0;
   logic [14:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic        verify_en = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        wea;
   logic [14:0] addra;
   logic [15:0] dina;
   logic [15:0] douta = '0;
   logic        busy;
   logic        done;
   logic        verify_err;
   logic [15:0] checksum;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [15:0] mem [0:32767];
   bit          corrupt_en = 1'b0;
   logic [14:0] corrupt_addr = '0;
   logic [15:0] corrupt_val = '0;

   logic [14:0] wr_a[$];
   logic [15:0] wr_d[$];
   int          wr_c[$];
   logic [14:0] addr_at[int];
   logic        wea_at[int];
   int          done_n = 0;
   int          done_cyc = 0;
   int          start_cyc = 0;
   logic [15:0] data_q[$];

   ram_burst_writer #(.ADDR_W(15), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
      .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr),
      .word_count(word_count), .verify_en(verify_en), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .wea(wea), .addra(addra),
      .dina(dina), .douta(douta), .busy(busy), .done(done),
      .verify_err(verify_err), .checksum(checksum)
   );

   always #5 clka = ~clka;

   always @(posedge clka) cyc <= cyc + 1;

   // Single-port synchronous RAM, one-cycle read latency, optional corrupted read
   always @(posedge clka) begin
      if (wea) mem[addra] <= dina;
      douta <= (corrupt_en && addra == corrupt_addr) ? corrupt_val : mem[addra];
   end

   // Port-A activity log sampled mid-cycle
   always @(negedge clka) begin
      addr_at[cyc] = addra;
      wea_at[cyc]  = wea;
      if (wea) begin
         wr_a.push_back(addra);
         wr_d.push_back(dina);
         wr_c.push_back(cyc);
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   task automatic clear_logs();
      wr_a.delete(); wr_d.delete(); wr_c.delete();
      done_n = 0; done_cyc = -1;
   endtask

   // Drives a full burst from data_q. mid_start >= 0 pulses a stray start after that word
   task automatic run_burst(input logic [14:0] base, input int n, input logic ver,
                            input int gap_pct, input int mid_start, output bit timeout);
      bit ok;
      int k;
      timeout = 1'b0;
      clear_logs();
      start = 1'b1; base_addr = base; word_count = 16'(n); verify_en = ver;
      start_cyc = cyc;
      @(posedge clka); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge clka); #1;
         end
         s_data = data_q[i]; s_valid = 1'b1;
         k = 0;
         while (1) begin
            ok = s_ready;
            @(posedge clka); #1;
            if (ok) break;
            if (++k > 20) begin timeout = 1'b1; break; end
         end
         s_valid = 1'b0;
         if (timeout) break;
         if (i == mid_start) begin
            start = 1'b1; base_addr = 15'h0; word_count = 16'd1;
            @(posedge clka); #1;
            start = 1'b0;
         end
      end
      k = 0;
      while (done_n == 0 && k < 100) begin
         @(posedge clka); #1;
         k++;
      end
      if (done_n == 0) timeout = 1'b1;
      @(posedge clka); #1;
   endtask

   task automatic test_reset();
      rsta = 1'b1;
      repeat (3) @(posedge clka);
      #1;
      n_tests++;
      if ({wea, addra, dina, s_ready, busy, done, verify_err, checksum} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got wea=%b addra=%h dina=%h rdy=%b busy=%b done=%b err=%b sum=%h, want all 0",
                  wea, addra, dina, s_ready, busy, done, verify_err, checksum);
      end
      rsta = 1'b0;
      @(posedge clka); #1;
   endtask

   task automatic test_basic();
      bit to;
      data_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      run_burst(15'h0000, 4, 1'b0, 0, -1, to);
      n_tests++;
      if (to || wr_a.size() != 4) begin
         n_fail++; $display("FAIL basic_count: got %0d writes timeout=%0d, want 4", wr_a.size(), to);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (wr_a[i] !== 15'(i) || wr_d[i] !== data_q[i] || wr_c[i] != wr_c[0] + i) begin
               n_fail++;
               $display("FAIL basic_write%0d: got a=%h d=%h c=%0d, want a=%h d=%h c=%0d",
                        i, wr_a[i], wr_d[i], wr_c[i], 15'(i), data_q[i], wr_c[0] + i);
            end
         end
         n_tests++;
         if (done_cyc != wr_c[3] + 1) begin
            n_fail++; $display("FAIL basic_done_time: got cycle %0d, want %0d", done_cyc, wr_c[3] + 1);
         end
      end
      n_tests++;
      if (checksum !== 16'h000A || verify_err !== 1'b0 || done_n != 1) begin
         n_fail++;
         $display("FAIL basic_status: got sum=%h err=%b dones=%0d, want 000a 0 1", checksum, verify_err, done_n);
      end
   endtask

   task automatic test_wrap_gaps();
      bit to;
      logic [14:0] ea;
      data_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      run_burst(15'h7FFE, 4, 1'b0, 100, -1, to);
      n_tests++;
      if (to || wr_a.size() != 4) begin
         n_fail++; $display("FAIL wrap_count: got %0d writes timeout=%0d, want 4", wr_a.size(), to);
      end else begin
         for (int i = 0; i < 4; i++) begin
            ea = 15'((32766 + i) % 32768);
            n_tests++;
            if (wr_a[i] !== ea || wr_d[i] !== 16'hFFFF || (i > 0 && wr_c[i] != wr_c[i-1] + 2)) begin
               n_fail++;
               $display("FAIL wrap_write%0d: got a=%h d=%h c=%0d, want a=%h d=ffff spaced 2",
                        i, wr_a[i], wr_d[i], wr_c[i], ea);
            end
         end
      end
      n_tests++;
      if (checksum !== 16'hFFFC) begin
         n_fail++; $display("FAIL wrap_checksum: got %h, want fffc", checksum);
      end
   endtask

   task automatic test_verify(input bit corrupt);
      bit to;
      int last;
      int rsum;
      logic exp_err;
      data_q = '{16'h1111, 16'h2222, 16'h3333};
      corrupt_en = corrupt; corrupt_addr = 15'h0101; corrupt_val = 16'h2223;
      run_burst(15'h0100, 3, 1'b1, 0, -1, to);
      rsum = 0;
      for (int i = 0; i < 3; i++)
         rsum += (corrupt && i == 1) ? 32'h2223 : int'(data_q[i]);
      exp_err = (16'(rsum) != 16'h6666);
      n_tests++;
      if (to || wr_a.size() != 3) begin
         n_fail++; $display("FAIL verify_count: got %0d writes timeout=%0d, want 3", wr_a.size(), to);
      end else begin
         last = wr_c[2];
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (addr_at[last + 1 + i] !== 15'(16'h0100 + i) || wea_at[last + 1 + i] !== 1'b0) begin
               n_fail++;
               $display("FAIL verify_read%0d: got a=%h we=%b, want a=%h we=0",
                        i, addr_at[last + 1 + i], wea_at[last + 1 + i], 15'(16'h0100 + i));
            end
         end
         n_tests++;
         if (done_cyc != last + 3 + RD_LAT + 2) begin
            n_fail++; $display("FAIL verify_done_time: got %0d, want %0d", done_cyc, last + 3 + RD_LAT + 2);
         end
      end
      n_tests++;
      if (checksum !== 16'h6666 || verify_err !== exp_err) begin
         n_fail++;
         $display("FAIL verify_status corrupt=%0d: got sum=%h err=%b, want 6666 %b", corrupt, checksum, verify_err, exp_err);
      end
      repeat (5) @(posedge clka);
      #1;
      n_tests++;
      if (verify_err !== exp_err) begin
         n_fail++; $display("FAIL verify_err_hold: got %b, want %b", verify_err, exp_err);
      end
      corrupt_en = 1'b0;
   endtask

   task automatic test_zero_and_ignored_start();
      bit to;
      data_q.delete();
      run_burst(15'h1234, 0, 1'b1, 0, -1, to);
      n_tests++;
      if (to || wr_a.size() != 0 || done_cyc != start_cyc + 2 || checksum !== 16'h0 || verify_err !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_count: got writes=%0d done_at=%0d sum=%h err=%b to=%0d, want 0 %0d 0000 0 0",
                  wr_a.size(), done_cyc, checksum, verify_err, to, start_cyc + 2);
      end
      data_q.delete();
      for (int i = 0; i < 4; i++) data_q.push_back(16'($urandom));
      run_burst(15'h0400, 4, 1'b0, 0, 1, to);
      n_tests++;
      if (to || wr_a.size() != 4 || done_n != 1) begin
         n_fail++; $display("FAIL busy_start_count: got writes=%0d dones=%0d to=%0d, want 4 1 0", wr_a.size(), done_n, to);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (wr_a[i] !== 15'(16'h0400 + i) || wr_d[i] !== data_q[i]) begin
               n_fail++;
               $display("FAIL busy_start_write%0d: got a=%h d=%h, want a=%h d=%h",
                        i, wr_a[i], wr_d[i], 15'(16'h0400 + i), data_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      int k;
      clear_logs();
      data_q.delete();
      for (int i = 0; i < 8; i++) data_q.push_back(16'($urandom));
      start = 1'b1; base_addr = 15'h2000; word_count = 16'd8; verify_en = 1'b1;
      @(posedge clka); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_data = data_q[i]; s_valid = 1'b1;
         k = 0;
         while (1) begin
            ok = s_ready;
            @(posedge clka); #1;
            if (ok || ++k > 20) break;
         end
      end
      s_data = data_q[2]; rsta = 1'b1;
      @(posedge clka); #1;
      rsta = 1'b0; s_valid = 1'b0;
      n_tests++;
      if ({wea, addra, dina, s_ready, busy, done, verify_err, checksum} !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: got wea=%b addra=%h dina=%h rdy=%b busy=%b sum=%h, want all 0",
                  wea, addra, dina, s_ready, busy, checksum);
      end
      repeat (6) @(posedge clka);
      #1;
      n_tests++;
      if (wr_a.size() != 2 || done_n != 0) begin
         n_fail++; $display("FAIL abort_activity: got writes=%0d dones=%0d, want 2 0", wr_a.size(), done_n);
      end
   endtask

   task automatic test_random(input int bursts);
      bit to;
      logic [14:0] base;
      logic        ver;
      int          n;
      int          sum;
      int          last;
      for (int b = 0; b < bursts; b++) begin
         base = (b % 2 == 0) ? 15'(32768 - $urandom_range(1, 4)) : 15'($urandom_range(0, 32767));
         n    = $urandom_range(1, 10);
         ver  = 1'($urandom_range(0, 1));
         data_q.delete();
         sum = 0;
         for (int i = 0; i < n; i++) begin
            data_q.push_back(16'($urandom));
            sum += int'(data_q[i]);
         end
         run_burst(base, n, ver, 30, -1, to);
         n_tests++;
         if (to || wr_a.size() != n || done_n != 1) begin
            n_fail++;
            $display("FAIL rand%0d_count: got writes=%0d dones=%0d to=%0d, want %0d 1 0", b, wr_a.size(), done_n, to, n);
            continue;
         end
         for (int i = 0; i < n; i++) begin
            n_tests++;
            if (wr_a[i] !== 15'((int'(base) + i) % 32768) || wr_d[i] !== data_q[i]) begin
               n_fail++;
               $display("FAIL rand%0d_write%0d: got a=%h d=%h, want a=%h d=%h", b, i, wr_a[i], wr_d[i],
                        15'((int'(base) + i) % 32768), data_q[i]);
            end
         end
         last = wr_c[n-1];
         n_tests++;
         if (checksum !== 16'(sum) || verify_err !== 1'b0 ||
             done_cyc != (ver ? last + n + RD_LAT + 2 : last + 1)) begin
            n_fail++;
            $display("FAIL rand%0d_status: got sum=%h err=%b done_at=%0d, want %h 0 %0d", b, checksum, verify_err,
                     done_cyc, 16'(sum), ver ? last + n + RD_LAT + 2 : last + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap_gaps();
      test_verify(1'b0);
      test_verify(1'b1);
      test_zero_and_ignored_start();
      test_reset_abort();
      test_random(1);
      test_random(6);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
